// File: rtl/elevator_if.sv
// Signal bundle between the elevator car controller and its floor/hall panel.
// The panel (master) drives requests and sensors; the controller (slave) drives the indicators.
interface elevator_if;
    logic       reqG;
    logic       reqF1;
    logic       reqF2;
    logic       reqF3;
    logic       overload;
    logic       firealarm;
    logic       person_detected;
    logic       door_open;
    logic       door_closed;
    logic [3:0] bcd_floor;
    logic [6:0] seg;
    logic [1:0] prox;

    modport master (
        output reqG, reqF1, reqF2, reqF3, overload, firealarm, person_detected,
        input  door_open, door_closed, bcd_floor, seg, prox
    );

    modport slave (
        input  reqG, reqF1, reqF2, reqF3, overload, firealarm, person_detected,
        output door_open, door_closed, bcd_floor, seg, prox
    );
endinterface

// File: rtl/elevator_ctrl.sv
// Four-floor elevator car controller: request latching, one-floor-per-FLOOR_TICKS travel,
// timed door cycle with obstruction/overload hold, and fire-alarm return to ground.
module elevator_ctrl #(
    parameter int FLOOR_TICKS = 2,
    parameter int DOOR_TICKS  = 3
) (
    input logic       clk,
    input logic       rst,
    elevator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN, FIRE} state_t;

    localparam int FW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [FW-1:0] MOVE_LOAD = FW'(FLOOR_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_TICKS);

    state_t        state, state_nxt;
    logic [1:0]    prox, prox_nxt, next_floor;
    logic [3:0]    pending, pending_nxt, req;
    logic          dir_up, dir_up_nxt;
    logic          door, door_nxt;
    logic [FW-1:0] move_cnt, move_cnt_nxt;
    logic [DW-1:0] door_cnt, door_cnt_nxt;
    logic [3:0]    bcd_q;
    logic [6:0]    seg_q;

    function automatic logic [3:0] above_mask(input logic [1:0] f);
        return 4'b1110 << f;
    endfunction

    function automatic logic [3:0] below_mask(input logic [1:0] f);
        return (4'b0001 << f) - 4'b0001;
    endfunction

    function automatic logic [6:0] seg_of(input logic [1:0] f);
        case (f)
            2'd0:    return 7'b0111111;
            2'd1:    return 7'b0000110;
            2'd2:    return 7'b1011011;
            default: return 7'b1001111;
        endcase
    endfunction

    assign req = {bus.reqF3, bus.reqF2, bus.reqF1, bus.reqG};

    // Saturating neighbour in the travel direction; the car never wraps past G or F3.
    assign next_floor = dir_up ? ((prox == 2'd3) ? prox : prox + 2'd1)
                               : ((prox == 2'd0) ? prox : prox - 2'd1);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt    = state;
        prox_nxt     = prox;
        pending_nxt  = bus.firealarm ? 4'b0000 : (pending | req);
        dir_up_nxt   = dir_up;
        door_nxt     = door;
        move_cnt_nxt = move_cnt;
        door_cnt_nxt = door_cnt;

        if (bus.firealarm && state != FIRE) begin
            state_nxt    = FIRE;
            door_nxt     = (prox == 2'd0);
            move_cnt_nxt = MOVE_LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (pending[prox] || bus.overload) begin
                        state_nxt         = DOOR_OPEN;
                        pending_nxt[prox] = 1'b0;
                        door_cnt_nxt      = DOOR_LOAD;
                        door_nxt          = 1'b1;
                    end else if (|pending) begin
                        state_nxt    = MOVE;
                        move_cnt_nxt = MOVE_LOAD;
                        if (dir_up ? ~|(pending & above_mask(prox)) : ~|(pending & below_mask(prox)))
                            dir_up_nxt = ~dir_up;
                    end
                end
                MOVE: begin
                    if (move_cnt == '0) begin
                        prox_nxt     = next_floor;
                        move_cnt_nxt = MOVE_LOAD;
                        if (pending[next_floor]) begin
                            state_nxt               = DOOR_OPEN;
                            pending_nxt[next_floor] = 1'b0;
                            door_cnt_nxt            = DOOR_LOAD;
                            door_nxt                = 1'b1;
                        end else if (dir_up ? ~|(pending & above_mask(next_floor))
                                            : ~|(pending & below_mask(next_floor))) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        move_cnt_nxt = move_cnt - 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if (pending[prox]) begin
                        pending_nxt[prox] = 1'b0;
                        door_cnt_nxt      = DOOR_LOAD;
                    end else if (bus.person_detected || bus.overload) begin
                        door_cnt_nxt = DOOR_LOAD;
                    end else if (door_cnt <= DW'(1)) begin
                        state_nxt = IDLE;
                        door_nxt  = 1'b0;
                    end else begin
                        door_cnt_nxt = door_cnt - 1'b1;
                    end
                end
                FIRE: begin
                    if (!bus.firealarm) begin
                        state_nxt    = DOOR_OPEN;
                        door_cnt_nxt = DOOR_LOAD;
                        door_nxt     = 1'b1;
                    end else if (prox != 2'd0) begin
                        if (move_cnt == '0) begin
                            prox_nxt     = prox - 2'd1;
                            move_cnt_nxt = MOVE_LOAD;
                            door_nxt     = (prox == 2'd1);
                        end else begin
                            move_cnt_nxt = move_cnt - 1'b1;
                        end
                    end else begin
                        door_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prox     <= 2'd0;
            pending  <= 4'b0000;
            dir_up   <= 1'b1;
            door     <= 1'b0;
            move_cnt <= '0;
            door_cnt <= '0;
            bcd_q    <= 4'd0;
            seg_q    <= 7'b0111111;
        end else begin
            state    <= state_nxt;
            prox     <= prox_nxt;
            pending  <= pending_nxt;
            dir_up   <= dir_up_nxt;
            door     <= door_nxt;
            move_cnt <= move_cnt_nxt;
            door_cnt <= door_cnt_nxt;
            bcd_q    <= {2'b00, prox_nxt};
            seg_q    <= seg_of(prox_nxt);
        end
    end

    assign bus.door_open   = door;
    assign bus.door_closed = ~door;
    assign bus.prox        = prox;
    assign bus.bcd_floor   = bcd_q;
    assign bus.seg         = seg_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: hand-derived scenario table plus randomized traffic
// compared every cycle against a behavioural car model.
module tb_elevator_ctrl;
    localparam int FLOOR_TICKS = 2;
    localparam int DOOR_TICKS  = 3;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_FIRE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    elevator_if bus();

    elevator_ctrl #(.FLOOR_TICKS(FLOOR_TICKS), .DOOR_TICKS(DOOR_TICKS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ovl;
        logic       fire;
        logic       person;
        int         ticks;
        int         prox;
        logic       door;
    } vec_t;

    vec_t vecs[$];

    // Behavioural car model state
    int       m_mode, m_floor, m_travel, m_door_left;
    bit       m_door, m_up;
    bit [3:0] m_pend;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic o, input logic f,
                                input logic p, input int t, input int pr, input logic d);
        vec_t v;
        v.rst = r; v.req = q; v.ovl = o; v.fire = f; v.person = p;
        v.ticks = t; v.prox = pr; v.door = d;
        return v;
    endfunction

    function automatic logic [6:0] seg_ref(input int f);
        case (f)
            0:       return 7'b0111111;
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            default: return 7'b1001111;
        endcase
    endfunction

    function automatic bit pend_above(input int f);
        for (int j = f + 1; j < 4; j++) if (m_pend[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_below(input int f);
        for (int j = 0; j < f; j++) if (m_pend[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic o, input logic f, input logic p);
        rst = r;
        {bus.reqF3, bus.reqF2, bus.reqF1, bus.reqG} = q;
        bus.overload        = o;
        bus.firealarm       = f;
        bus.person_detected = p;
    endtask

    task automatic model_step();
        bit [3:0] np;
        bit [3:0] r;
        r = {bus.reqF3, bus.reqF2, bus.reqF1, bus.reqG};
        if (rst) begin
            m_mode = M_IDLE; m_floor = 0; m_pend = '0; m_up = 1'b1;
            m_door = 1'b0; m_travel = 0; m_door_left = 0;
            return;
        end
        np = bus.firealarm ? 4'b0000 : (m_pend | r);
        if (bus.firealarm && m_mode != M_FIRE) begin
            m_mode = M_FIRE; m_door = (m_floor == 0); m_travel = FLOOR_TICKS;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (m_pend[m_floor] || bus.overload) begin
                        m_mode = M_DOOR; m_door = 1'b1; m_door_left = DOOR_TICKS; np[m_floor] = 1'b0;
                    end else if (m_pend != 0) begin
                        if (!(m_up ? pend_above(m_floor) : pend_below(m_floor))) m_up = !m_up;
                        m_mode = M_MOVE; m_travel = FLOOR_TICKS;
                    end
                end
                M_MOVE: begin
                    m_travel--;
                    if (m_travel == 0) begin
                        m_floor = m_up ? ((m_floor < 3) ? m_floor + 1 : 3) : ((m_floor > 0) ? m_floor - 1 : 0);
                        m_travel = FLOOR_TICKS;
                        if (m_pend[m_floor]) begin
                            m_mode = M_DOOR; m_door = 1'b1; m_door_left = DOOR_TICKS; np[m_floor] = 1'b0;
                        end else if (!(m_up ? pend_above(m_floor) : pend_below(m_floor))) begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                M_DOOR: begin
                    if (m_pend[m_floor]) begin
                        np[m_floor] = 1'b0; m_door_left = DOOR_TICKS;
                    end else if (bus.person_detected || bus.overload) begin
                        m_door_left = DOOR_TICKS;
                    end else begin
                        m_door_left--;
                        if (m_door_left == 0) begin
                            m_mode = M_IDLE; m_door = 1'b0;
                        end
                    end
                end
                default: begin
                    if (!bus.firealarm) begin
                        m_mode = M_DOOR; m_door = 1'b1; m_door_left = DOOR_TICKS;
                    end else if (m_floor > 0) begin
                        m_travel--;
                        if (m_travel == 0) begin
                            m_floor--; m_travel = FLOOR_TICKS;
                        end
                        m_door = (m_floor == 0);
                    end else begin
                        m_door = 1'b1;
                    end
                end
            endcase
        end
        m_pend = np;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model prox", 32'(bus.prox), 32'(m_floor));
        check("model door_open", 32'(bus.door_open), 32'(m_door));
        check("model door_closed", 32'(bus.door_closed), 32'(!m_door));
        check("model bcd_floor", 32'(bus.bcd_floor), 32'(m_floor));
        check("model seg", 32'(bus.seg), 32'(seg_ref(m_floor)));
    endtask

    initial begin
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 2, 0, 0));  // reset
        vecs.push_back(mk(0, 4'h8, 0, 0, 0, 2, 0, 0));  // F3 requested from G
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 2, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 3, 1));  // arrive F3, door opens
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 3, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 3, 0));  // closes DOOR_TICKS later
        vecs.push_back(mk(0, 4'h8, 0, 0, 0, 1, 3, 0));  // reopen at F3
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 3, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 2, 3, 1));  // person holds door
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 3, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 4'h1, 0, 0, 0, 1, 3, 0));  // reqG
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 2, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 0, 1, 1, 0));  // reqF2 after passing F2
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 4, 2, 1));  // climb back to F2
        vecs.push_back(mk(0, 4'h8, 0, 0, 0, 1, 2, 1));  // F3 pending
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 1, 2, 0));  // fire: door shuts
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 4, 0, 1));  // parked at G, open
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 3, 0, 0));  // F3 was dropped
        vecs.push_back(mk(0, 4'h2, 1, 0, 0, 1, 0, 1));  // overload opens, F1 pending
        vecs.push_back(mk(0, 4'h0, 1, 0, 0, 3, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 2, 1, 1));  // serviced F1
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 3, 2, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0, 0));  // reset mid-travel

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].ovl, vecs[i].fire, vecs[i].person);
            repeat (vecs[i].ticks) tick();
            check($sformatf("vec%0d prox", i), 32'(bus.prox), 32'(vecs[i].prox));
            check($sformatf("vec%0d door_open", i), 32'(bus.door_open), 32'(vecs[i].door));
            check($sformatf("vec%0d seg", i), 32'(bus.seg), 32'(seg_ref(vecs[i].prox)));
        end

        begin
            logic fire_r = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                logic [3:0] q;
                for (int b = 0; b < 4; b++) q[b] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 99) < 3) fire_r = ~fire_r;
                drive($urandom_range(0, 499) == 0, q, $urandom_range(0, 19) == 0,
                      fire_r, $urandom_range(0, 9) == 0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
